// File: rtl/avalon_mm_slave.sv
// avalon_mm_slave
// Avalon-MM slave fronting a small bank of 32-bit registers. Each accepted
// transfer costs two clocks: the accept edge (one wait state) plus one
// acknowledge cycle in which waitrequest is low and readdata is valid.
//
// Ports:
//   clk         - system clock, rising-edge active
//   reset       - asynchronous, active-high reset
//   address     - byte address; word index = address[5:2], [1:0] ignored
//   read        - read request
//   write       - write request (wins over read when both are high)
//   chipselect  - slave select; requests ignored while low
//   writedata   - write data (full-word writes only)
//   waitrequest - high while the master must hold its request
//   readdata    - registered read data, valid while waitrequest is low after a read
//
// Register map: word 0 is a read-only ID constant, words 1..NUM_REGS-1 are RW.
// Addresses with any bit set above the register window read as 0 and ignore writes.

module avalon_mm_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA5A5_0001
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  read,
    input  logic                  write,
    input  logic                  chipselect,
    input  logic [DATA_WIDTH-1:0] writedata,
    output logic                  waitrequest,
    output logic [DATA_WIDTH-1:0] readdata
);

    localparam int IDX_W = $clog2(NUM_REGS);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] readdata_q;
    logic [DATA_WIDTH-1:0] readdata_d;

    logic                  req_s;
    logic                  accept_s;
    logic                  in_range_s;
    logic [IDX_W-1:0]      idx_s;
    logic                  wr_en_s;
    logic                  rd_en_s;
    logic [DATA_WIDTH-1:0] rd_val_s;
    logic                  unused_addr_s;

    // Byte-lane bits play no part in decoding.
    assign unused_addr_s = ^address[1:0];

    assign req_s      = chipselect & (read | write);
    assign idx_s      = address[IDX_W+1:2];
    assign in_range_s = (address[ADDR_WIDTH-1:IDX_W+2] == {(ADDR_WIDTH-IDX_W-2){1'b0}});
    // Only an IDLE request is executed; a request still high in ACK is the
    // tail of the transfer that was just completed.
    assign accept_s   = (state_q == IDLE) & req_s;
    assign wr_en_s    = accept_s & write & in_range_s & (idx_s != {IDX_W{1'b0}});
    assign rd_en_s    = accept_s & read & ~write;

    // Reset forces a wait state so no master can complete a transfer while held.
    assign waitrequest = reset | ((state_q == IDLE) & req_s);
    assign readdata    = readdata_q;

    // Decode the value a read of the current address would return.
    always_comb begin
        rd_val_s = {DATA_WIDTH{1'b0}};
        if (!in_range_s) begin
            rd_val_s = {DATA_WIDTH{1'b0}};
        end else if (idx_s == {IDX_W{1'b0}}) begin
            rd_val_s = ID_VALUE;
        end else begin
            rd_val_s = regs_q[idx_s];
        end
    end

    // Next-state and next-readdata logic of the two-state handshake FSM.
    always_comb begin
        state_d    = state_q;
        readdata_d = readdata_q;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    state_d = ACK;
                end else begin
                    state_d = IDLE;
                end
                if (rd_en_s) begin
                    readdata_d = rd_val_s;
                end else begin
                    readdata_d = readdata_q;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and registered read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            readdata_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            readdata_q <= readdata_d;
        end
    end

    // Register bank; word 0 is never written (its read value is ID_VALUE).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_q[idx_s] <= writedata;
        end
    end

endmodule

// File: tb/tb_avalon_mm_slave.sv
// tb_avalon_mm_slave
// Directed and randomized register traffic against avalon_mm_slave, checked
// against a word-array reference model of the register map.

module tb_avalon_mm_slave;

    localparam logic [31:0] ID = 32'hA5A5_0001;

    logic        clk;
    logic        reset;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic        chipselect;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;

    int          checks;
    int          failures;
    logic [31:0] model [16];
    logic [31:0] last_rd;

    avalon_mm_slave dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .read        (read),
        .write       (write),
        .chipselect  (chipselect),
        .writedata   (writedata),
        .waitrequest (waitrequest),
        .readdata    (readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:6] != 26'd0) return 32'h0;
        if (a[5:2] == 4'd0) return ID;
        return model[a[5:2]];
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d);
        if (a[31:6] == 26'd0 && a[5:2] != 4'd0) model[a[5:2]] = d;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        last_rd = 32'h0;
    endtask

    // One bus transfer; highs counts sampled cycles with waitrequest high.
    task automatic xfer(input logic rd, input logic wr, input logic cs,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rdat, output int highs);
        int  n;
        bit  done;
        address    = a;
        read       = rd;
        write      = wr;
        chipselect = cs;
        writedata  = d;
        highs = 0;
        n     = 0;
        done  = 1'b0;
        #1;
        if (waitrequest) highs++;
        while (!done && n < 8) begin
            @(posedge clk);
            #1;
            n++;
            if (waitrequest) highs++;
            else done = 1'b1;
        end
        check("xfer_completed", {31'd0, done}, 32'd1);
        rdat       = readdata;
        read       = 1'b0;
        write      = 1'b0;
        chipselect = 1'b0;
    endtask

    // Transfer plus all checks derived from the reference model.
    task automatic run_op(input logic rd, input logic wr, input logic cs,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdat);
        int          highs;
        logic [31:0] exp;
        xfer(rd, wr, cs, a, d, rdat, highs);
        check("wait_cycles", highs, cs ? 32'd1 : 32'd0);
        if (cs && wr) begin
            model_write(a, d);
            check("rd_hold_on_write", rdat, last_rd);
        end else if (cs && rd) begin
            exp = model_read(a);
            check("read_data", rdat, exp);
            last_rd = exp;
        end else begin
            check("rd_hold_no_req", rdat, last_rd);
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        logic [31:0] d;
        int          op;
        int          gap;
        logic        cs;
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        address    = 32'h0;
        read       = 1'b0;
        write      = 1'b0;
        chipselect = 1'b0;
        writedata  = 32'h0;
        model_reset();

        #13;
        check("reset_waitrequest", {31'd0, waitrequest}, 32'd1);
        check("reset_readdata", readdata, 32'h0);
        #10 reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_waitrequest", {31'd0, waitrequest}, 32'd0);

        // ID register and cleared RW registers
        run_op(1'b1, 1'b0, 1'b1, 32'h00, 32'h0, r);
        check("id_read", r, 32'hA5A5_0001);
        for (int i = 1; i < 16; i++) begin
            run_op(1'b1, 1'b0, 1'b1, i * 4, 32'h0, r);
            check("rw_after_reset", r, 32'h0);
        end

        // Basic writes and readback
        run_op(1'b0, 1'b1, 1'b1, 32'h04, 32'hDEAD_BEEF, r);
        run_op(1'b1, 1'b0, 1'b1, 32'h04, 32'h0, r);
        check("read_0x04", r, 32'hDEAD_BEEF);
        run_op(1'b0, 1'b1, 1'b1, 32'h3C, 32'h1234_5678, r);
        run_op(1'b1, 1'b0, 1'b1, 32'h3C, 32'h0, r);
        check("read_0x3C", r, 32'h1234_5678);
        run_op(1'b1, 1'b0, 1'b1, 32'h20, 32'h0, r);
        check("read_0x20_untouched", r, 32'h0);

        // Read-only ID and out-of-range accesses
        run_op(1'b0, 1'b1, 1'b1, 32'h00, 32'hFFFF_FFFF, r);
        run_op(1'b1, 1'b0, 1'b1, 32'h00, 32'h0, r);
        check("id_after_write", r, 32'hA5A5_0001);
        run_op(1'b0, 1'b1, 1'b1, 32'h100, 32'h55AA_55AA, r);
        run_op(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, r);
        check("read_out_of_range", r, 32'h0);
        for (int i = 1; i < 16; i++) begin
            run_op(1'b1, 1'b0, 1'b1, i * 4, 32'h0, r);
        end

        // chipselect low ignores the write
        run_op(1'b0, 1'b1, 1'b0, 32'h08, 32'h1, r);
        run_op(1'b1, 1'b0, 1'b1, 32'h08, 32'h0, r);
        check("read_0x08_no_cs", r, 32'h0);

        // Back-to-back write then read, then unaligned read
        run_op(1'b0, 1'b1, 1'b1, 32'h10, 32'hCAFE_F00D, r);
        run_op(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, r);
        check("b2b_read_0x10", r, 32'hCAFE_F00D);
        run_op(1'b1, 1'b0, 1'b1, 32'h11, 32'h0, r);
        check("unaligned_read_0x11", r, 32'hCAFE_F00D);

        // read and write both high behaves as a write
        run_op(1'b1, 1'b1, 1'b1, 32'h18, 32'h0BAD_F00D, r);
        run_op(1'b1, 1'b0, 1'b1, 32'h18, 32'h0, r);
        check("rw_both_is_write", r, 32'h0BAD_F00D);

        // Randomized traffic with idle gaps
        for (int k = 0; k < 120; k++) begin
            case ($urandom_range(0, 9))
                0:       a = {30'd0, 2'($urandom_range(0, 3))};
                8, 9:    a = $urandom | 32'h0000_0040;
                default: a = {26'd0, 4'($urandom_range(1, 15)), 2'($urandom_range(0, 3))};
            endcase
            d   = $urandom;
            op  = $urandom_range(0, 3);
            cs  = ($urandom_range(0, 7) != 0);
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            run_op((op != 1), (op == 1 || op == 2), cs, a, d, r);
        end

        // Asynchronous reset mid-clock
        run_op(1'b0, 1'b1, 1'b1, 32'h14, 32'h77, r);
        run_op(1'b1, 1'b0, 1'b1, 32'h14, 32'h0, r);
        check("read_0x14_before_reset", r, 32'h77);
        address    = 32'h1C;
        writedata  = 32'hFFFF_0000;
        write      = 1'b1;
        chipselect = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("async_reset_waitrequest", {31'd0, waitrequest}, 32'd1);
        check("async_reset_readdata", readdata, 32'h0);
        @(posedge clk);
        #2;
        write      = 1'b0;
        chipselect = 1'b0;
        #2 reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        run_op(1'b1, 1'b0, 1'b1, 32'h14, 32'h0, r);
        check("read_0x14_after_reset", r, 32'h0);
        run_op(1'b1, 1'b0, 1'b1, 32'h1C, 32'h0, r);
        check("aborted_write_0x1C", r, 32'h0);
        run_op(1'b1, 1'b0, 1'b1, 32'h00, 32'h0, r);
        check("id_after_reset", r, 32'hA5A5_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/avalon_mm_slave.md
Name: avalon_mm_slave

Overview:
- Avalon-MM memory-mapped slave containing a small 32-bit register bank; it is the target block for register-access verification.
- A bus master reaches it through the standard address/read/write/chipselect/waitrequest handshake.
- Every accepted transfer inserts exactly one wait state, so each access takes two clocks.

Parameters:
- ADDR_WIDTH, 32, width of byte address bus
- DATA_WIDTH, 32, width of read/write data
- NUM_REGS, 16, number of 32-bit registers, word-addressed
- ID_VALUE, 32'hA5A5_0001, constant returned by read-only register 0

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- address  input  ADDR_WIDTH  byte address; word index = address[5:2]; address[1:0] ignored
- read  input  1  read request
- write  input  1  write request
- chipselect  input  1  slave select; requests are ignored when low
- writedata  input  DATA_WIDTH  write data
- waitrequest  output  1  high = master must hold request stable
- readdata  output  DATA_WIDTH  read data; valid in the cycle where waitrequest is low after a read

Behaviour:
- Request definition: req = chipselect & (read | write). If read and write are both high, the transfer is a write and readdata is unchanged.
- Register map:
  - Offset 0x00: read-only, returns ID_VALUE; writes ignored.
  - Offsets 0x04..0x3C: read/write, full 32-bit writes (no byte enables).
- Out-of-range addresses: any address with address[ADDR_WIDTH-1:6] != 0 is out of range. Reads return 0; writes are ignored. No error signalling.
- Two-state FSM with states IDLE and ACK.
  - IDLE: waitrequest = req (combinational). On clk rising edge with req:
    - write: target register updated with writedata.
    - read: readdata register loaded with addressed value.
    - Next state is ACK.
  - IDLE with no req: stay in IDLE; readdata holds its value.
  - ACK: waitrequest = 0. Next state is always IDLE, whether or not req is still high. A request still asserted in ACK is the tail of the completed transfer and is not re-executed.
- Timing:
  - Accept edge T (IDLE with req).
  - waitrequest low from T until T+1.
  - Master samples readdata and deasserts the request anywhere in that window.
  - Back-to-back requests: each costs 2 cycles, and waitrequest re-asserts in IDLE.
- Reset (asynchronous, while high):
  - State = IDLE.
  - All RW registers = 0.
  - readdata = 0.
  - waitrequest forced to 1 while reset is asserted; after release it follows the FSM rule.
- Reset mid-transfer aborts the transfer: no register update occurs on an edge where reset is high.
- readdata is registered, never combinational from address.

Test Plan:
- Reset then read 0x00 -> waitrequest high for 1 cycle then low; readdata = 0xA5A50001. Reading 0x04..0x3C after reset returns 0.
- Write 0x04 = 0xDEADBEEF, read 0x04 -> 0xDEADBEEF. Write 0x3C = 0x12345678, read back -> 0x12345678; the other registers remain 0.
- Write 0x00 = 0xFFFFFFFF, read 0x00 -> still 0xA5A50001. Write 0x100 = 0x55AA55AA, read 0x100 -> 0, and no in-range register changes.
- Write 0x08 = 0x1 with chipselect = 0 -> waitrequest stays 0, register unchanged. Read 0x08 with chipselect = 1 -> 0.
- Back-to-back: write 0x10 = 0xCAFEF00D, then immediately read 0x10 -> each transfer shows exactly one waitrequest cycle; read returns 0xCAFEF00D. Read 0x11 (unaligned) -> 0xCAFEF00D.
- Write 0x14 = 0x77, then assert reset asynchronously mid-clock -> waitrequest = 1 immediately. After release, read 0x14 -> 0.
